mux_n_stream: RTL

- Parametrised N-channel successor to the team's 2:1 width-parametrised mux.
- Selects one of NUM_CH input streams onto a single registered output stream with valid/ready handshakes.
- Two selection modes: fixed (external `sel`) and round-robin (fair arbitration).
- Sits between multiple data producers and one shared consumer; one output register stage.

---
 rtl/mux_n_stream_pkg.sv | 11 +
 rtl/mux_n_stream_rr_arbiter.sv | 28 ++
 rtl/mux_n_stream.sv | 60 ++++++
 3 files changed

// File: rtl/mux_n_stream_pkg.sv
// mux_n_stream_pkg: shared mode constants and index-width helper for the N-channel stream mux
package mux_n_stream_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mux_n_stream_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority search starting just after last_grant
module rr_arbiter
    import mux_n_stream_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SEL_W = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);
    always_comb begin
        int idx;
        grant = '0;
        grant_valid = 1'b0;
        idx = 0;
        // walk from farthest to nearest so the nearest requester is the one left standing
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            idx = idx >= NUM_CH ? idx - NUM_CH : idx;
            if (req[idx]) begin
                grant = SEL_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_n_stream.sv
// mux_n_stream: N-to-1 valid/ready stream mux, fixed or round-robin select, one output register
module mux_n_stream
    import mux_n_stream_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NUM_CH = 4,
    localparam int SEL_W = clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             fixed_valid;
    logic             load_en;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .grant_valid(rr_valid)
    );

    // out-of-range sel shifts the one-hot mask out of the vector, so no grant results
    assign fixed_valid = (int'(sel) < NUM_CH) && |(in_valid & (NUM_CH'(1) << sel));
    assign grant       = mode == MODE_RR ? rr_grant : sel;
    assign grant_valid = mode == MODE_RR ? rr_valid : fixed_valid;
    assign load_en     = !out_valid || out_ready;
    assign in_ready    = (load_en && grant_valid) ? NUM_CH'(1) << grant : '0;
    assign grant_data  = WIDTH'(in_data >> (int'(grant) * WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data   <= grant_data;
                out_ch     <= grant;
                last_grant <= grant;
            end
        end
    end
endmodule
